// File: rtl/down_counter_mod.sv
// Modulo-MODULUS down counter digit for cascaded timers, with clamped load,
// wrap or one-shot expiry, and a combinational borrow for ripple cascades.
module down_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int INIT    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow_out,
  output logic             expired
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  generate
    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH)) || (INIT < 0) || (INIT >= MODULUS)) begin : gBadParams
      $error("down_counter_mod: illegal MODULUS/INIT for the given WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Leaving one-shot mode drops a stale expiry even while the digit holds.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q & oneshot;
    if (load) begin
      count_d   = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      expired_d = 1'b0;
    end else if (enable) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (!oneshot) begin
        count_d = MAX_VAL;
      end else begin
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= INIT_VAL;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign q          = count_q;
  assign zero       = (count_q == '0);
  assign expired    = expired_q;
  assign borrow_out = enable & ~load & zero & ~(oneshot & expired_q);

endmodule
